writeback: RTL and testbench

- Final pipeline stage of the ECAP5-DPROC core, directly upstream of the register file write port.
- Accepts retiring instructions from the memory stage over a valid/ready handshake and aligns and extends load data.
- Registers the result and drives the single register-file write port (write, waddr, wdata) one cycle later.
- Maintains a 64-bit retired-instruction counter for the CSR unit.

---
 rtl/ecap5_dproc_pkg.sv | 21 ++
 rtl/writeback_load_align.sv | 33 +++
 rtl/writeback.sv | 100 ++++++++++
 tb/tb_writeback.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared definitions for the ECAP5-DPROC pipeline: data widths and load size encodings.
package ecap5_dproc_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] LOAD_BYTE = 2'd0;
    localparam logic [1:0] LOAD_HALF = 2'd1;
    localparam logic [1:0] LOAD_WORD = 2'd2;

    // Extend a value whose meaningful part is its low 'bits' bits; bits above are zero on entry.
    function automatic logic [XLEN-1:0] extend_low(input logic [XLEN-1:0] value,
                                                   input logic            sign_bit,
                                                   input logic            zero_ext,
                                                   input logic [XLEN-1:0] keep_mask);
        logic [XLEN-1:0] fill;
        fill = (sign_bit && !zero_ext) ? ~keep_mask : {XLEN{1'b0}};
        return (value & keep_mask) | fill;
    endfunction

endpackage

// File: rtl/writeback_load_align.sv
// load_align: shifts a raw bus word by the byte offset and extends byte/half loads.
// Purely combinational so it can be unit-tested on its own.
module load_align
    import ecap5_dproc_pkg::*;
(
    input  logic [XLEN-1:0] i_mem_data,
    input  logic [1:0]      i_offset,
    input  logic [1:0]      i_size,
    input  logic            i_is_unsigned,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_shifted;

    // Shift by whole bytes; zeros enter from the top, which handles a misaligned half at offset 3.
    always_comb begin
        w_shifted = i_mem_data >> {i_offset, 3'b000};
    end

    // Select and extend according to the access size; the reserved encoding behaves as a word.
    always_comb begin
        o_data = i_mem_data;
        case (i_size)
            LOAD_BYTE: o_data = extend_low(w_shifted, w_shifted[7], i_is_unsigned,
                                           32'h0000_00FF);
            LOAD_HALF: o_data = extend_low(w_shifted, w_shifted[15], i_is_unsigned,
                                           32'h0000_FFFF);
            LOAD_WORD: o_data = i_mem_data;
            default:   o_data = i_mem_data;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// writeback: final ECAP5-DPROC stage. Accepts retiring instructions, aligns load data,
// registers the register-file write and counts retired instructions.
// Optional feature macro: WRITEBACK_FORWARD_EN adds a same-cycle bypass (fwd_* ports).
module writeback
    import ecap5_dproc_pkg::*;
#(
    parameter logic [63:0] RESET_INSTRET = 64'd0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  input_valid_i,
    output logic                  input_ready_o,
    input  logic                  halt_i,
    input  logic                  reg_write_i,
    input  logic [REG_ADDR_W-1:0] reg_addr_i,
    input  logic [XLEN-1:0]       result_i,
    input  logic                  load_i,
    input  logic [1:0]            load_size_i,
    input  logic                  load_unsigned_i,
    input  logic [1:0]            load_offset_i,
    input  logic [XLEN-1:0]       mem_data_i,
`ifdef WRITEBACK_FORWARD_EN
    output logic                  fwd_valid_o,
    output logic [REG_ADDR_W-1:0] fwd_addr_o,
    output logic [XLEN-1:0]       fwd_data_o,
`endif
    output logic                  write_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic [63:0]           instret_o
);

    logic                  w_ready;
    logic                  w_transfer;
    logic                  w_wen;
    logic [XLEN-1:0]       w_load_data;
    logic [XLEN-1:0]       w_data;

    logic                  r_write;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]       r_wdata;
    logic [63:0]           r_instret;

    load_align u_load_align (
        .i_mem_data    (mem_data_i),
        .i_offset      (load_offset_i),
        .i_size        (load_size_i),
        .i_is_unsigned (load_unsigned_i),
        .o_data        (w_load_data)
    );

    // Handshake, x0 suppression and result selection for the incoming instruction.
    always_comb begin
        w_ready    = !rst_i && !halt_i;
        w_transfer = input_valid_i && w_ready;
        w_wen      = reg_write_i && (reg_addr_i != 5'd0);
        if (load_i) begin
            w_data = w_load_data;
        end else begin
            w_data = result_i;
        end
    end

    // Output register and retired-instruction counter; write is a single-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_write   <= 1'b0;
            r_waddr   <= 5'd0;
            r_wdata   <= 32'd0;
            r_instret <= RESET_INSTRET;
        end else begin
            r_write <= w_transfer && w_wen;
            if (w_transfer) begin
                r_waddr   <= reg_addr_i;
                r_wdata   <= w_data;
                r_instret <= r_instret + 64'd1;
            end else begin
                r_waddr   <= r_waddr;
                r_wdata   <= r_wdata;
                r_instret <= r_instret;
            end
        end
    end

    assign input_ready_o = w_ready;
    assign write_o       = r_write;
    assign waddr_o       = r_waddr;
    assign wdata_o       = r_wdata;
    assign instret_o     = r_instret;

`ifdef WRITEBACK_FORWARD_EN
    // Same-cycle bypass of the transfer being accepted, so decode can skip the register file.
    always_comb begin
        fwd_valid_o = w_transfer && w_wen;
        fwd_addr_o  = reg_addr_i;
        fwd_data_o  = w_data;
    end
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed, table-driven bench for writeback. A second instance with an all-ones
// counter reset value covers instret wrap-around.
module tb_writeback;

    logic        clk;
    logic        rst_i;
    logic        input_valid_i;
    logic        halt_i;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] result_i;
    logic        load_i;
    logic [1:0]  load_size_i;
    logic        load_unsigned_i;
    logic [1:0]  load_offset_i;
    logic [31:0] mem_data_i;

    logic        ready_a, write_a, ready_b, write_b;
    logic [4:0]  waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic [63:0] instret_a, instret_b;
`ifdef WRITEBACK_FORWARD_EN
    logic        fv_a, fv_b;
    logic [4:0]  fa_a, fa_b;
    logic [31:0] fd_a, fd_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_instret;

    writeback dut (
        .clk_i(clk), .rst_i(rst_i), .input_valid_i(input_valid_i), .input_ready_o(ready_a),
        .halt_i(halt_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
        .result_i(result_i), .load_i(load_i), .load_size_i(load_size_i),
        .load_unsigned_i(load_unsigned_i), .load_offset_i(load_offset_i),
        .mem_data_i(mem_data_i),
`ifdef WRITEBACK_FORWARD_EN
        .fwd_valid_o(fv_a), .fwd_addr_o(fa_a), .fwd_data_o(fd_a),
`endif
        .write_o(write_a), .waddr_o(waddr_a), .wdata_o(wdata_a), .instret_o(instret_a)
    );

    writeback #(.RESET_INSTRET(64'hFFFF_FFFF_FFFF_FFFF)) dut_wrap (
        .clk_i(clk), .rst_i(rst_i), .input_valid_i(input_valid_i), .input_ready_o(ready_b),
        .halt_i(halt_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
        .result_i(result_i), .load_i(load_i), .load_size_i(load_size_i),
        .load_unsigned_i(load_unsigned_i), .load_offset_i(load_offset_i),
        .mem_data_i(mem_data_i),
`ifdef WRITEBACK_FORWARD_EN
        .fwd_valid_o(fv_b), .fwd_addr_o(fa_b), .fwd_data_o(fd_b),
`endif
        .write_o(write_b), .waddr_o(waddr_b), .wdata_o(wdata_b), .instret_o(instret_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [31:0] result;
        logic        load;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] mem;
        logic        exp_write;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [4:0] addr, input logic [31:0] res,
                         input logic ld, input logic [1:0] sz, input logic uns,
                         input logic [1:0] off, input logic [31:0] mem);
        reg_write_i = rw; reg_addr_i = addr; result_i = res; load_i = ld;
        load_size_i = sz; load_unsigned_i = uns; load_offset_i = off; mem_data_i = mem;
    endtask

    initial begin
        //          rw  addr   result         load size   uns   off    mem            ewr   ewdata
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,         1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,         1'b0, 32'h00001234};
        vecs[2]  = '{1'b1, 5'd3,  32'h0,        1'b1, 2'd0, 1'b0, 2'd3, 32'h80FF7F01, 1'b1, 32'hFFFFFF80};
        vecs[3]  = '{1'b1, 5'd3,  32'h0,        1'b1, 2'd0, 1'b1, 2'd3, 32'h80FF7F01, 1'b1, 32'h00000080};
        vecs[4]  = '{1'b1, 5'd4,  32'h0,        1'b1, 2'd1, 1'b0, 2'd2, 32'h80010000, 1'b1, 32'hFFFF8001};
        vecs[5]  = '{1'b1, 5'd6,  32'h0,        1'b1, 2'd2, 1'b0, 2'd0, 32'h80010000, 1'b1, 32'h80010000};
        vecs[6]  = '{1'b1, 5'd7,  32'h0,        1'b1, 2'd2, 1'b0, 2'd3, 32'h12345678, 1'b1, 32'h12345678};
        vecs[7]  = '{1'b1, 5'd8,  32'h0,        1'b1, 2'd3, 1'b0, 2'd1, 32'hCAFEBABE, 1'b1, 32'hCAFEBABE};
        vecs[8]  = '{1'b1, 5'd9,  32'h0,        1'b1, 2'd1, 1'b0, 2'd3, 32'h80000000, 1'b1, 32'h00000080};
        vecs[9]  = '{1'b1, 5'd10, 32'h0,        1'b1, 2'd0, 1'b0, 2'd1, 32'h00008000, 1'b1, 32'hFFFFFF80};
        vecs[10] = '{1'b1, 5'd11, 32'h0,        1'b1, 2'd1, 1'b1, 2'd0, 32'h0000F00F, 1'b1, 32'h0000F00F};
        vecs[11] = '{1'b0, 5'd12, 32'h00000055, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0,         1'b0, 32'h00000055};
        vecs[12] = '{1'b1, 5'd31, 32'h0,        1'b1, 2'd0, 1'b0, 2'd2, 32'h007F0000, 1'b1, 32'h0000007F};

        rst_i = 1'b1; input_valid_i = 1'b0; halt_i = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        step(); step();
        input_valid_i = 1'b1;
        drive(1'b1, 5'd5, 32'h1111, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        #1;
        chk("rst_ready", {63'd0, ready_a}, 64'd0);
        step();
        chk("rst_write", {63'd0, write_a}, 64'd0);
        chk("rst_waddr", {59'd0, waddr_a}, 64'd0);
        chk("rst_wdata", {32'd0, wdata_a}, 64'd0);
        chk("rst_instret", instret_a, 64'd0);
        chk("rst_instret_wrapinst", instret_b, 64'hFFFF_FFFF_FFFF_FFFF);
        input_valid_i = 1'b0;
        rst_i = 1'b0;
        step();
        chk("post_rst_write", {63'd0, write_a}, 64'd0);
        chk("post_rst_wdata", {32'd0, wdata_a}, 64'd0);
        chk("post_rst_instret", instret_a, 64'd0);
        chk("ready_idle", {63'd0, ready_a}, 64'd1);

        exp_instret = 64'd0;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rw, vecs[i].addr, vecs[i].result, vecs[i].load, vecs[i].size,
                  vecs[i].uns, vecs[i].off, vecs[i].mem);
            input_valid_i = 1'b1;
`ifdef WRITEBACK_FORWARD_EN
            #1;
            chk($sformatf("v%0d_fwd_valid", i), {63'd0, fv_a}, {63'd0, vecs[i].exp_write});
            chk($sformatf("v%0d_fwd_data", i), {32'd0, fd_a}, {32'd0, vecs[i].exp_wdata});
`endif
            step();
            input_valid_i = 1'b0;
            exp_instret = exp_instret + 64'd1;
            chk($sformatf("v%0d_write", i), {63'd0, write_a}, {63'd0, vecs[i].exp_write});
            chk($sformatf("v%0d_waddr", i), {59'd0, waddr_a}, {59'd0, vecs[i].addr});
            chk($sformatf("v%0d_wdata", i), {32'd0, wdata_a}, {32'd0, vecs[i].exp_wdata});
            chk($sformatf("v%0d_instret", i), instret_a, exp_instret);
            if (i == 0) chk("wrap_instret", instret_b, 64'd0);
            step();
            chk($sformatf("v%0d_write_pulse", i), {63'd0, write_a}, 64'd0);
            chk($sformatf("v%0d_wdata_hold", i), {32'd0, wdata_a}, {32'd0, vecs[i].exp_wdata});
        end

        // Halt holds off acceptance while valid is asserted.
        drive(1'b1, 5'd9, 32'h0000A5A5, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        input_valid_i = 1'b1;
        halt_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("halt_ready", {63'd0, ready_a}, 64'd0);
            step();
            chk("halt_write", {63'd0, write_a}, 64'd0);
            chk("halt_instret", instret_a, exp_instret);
        end
        halt_i = 1'b0;
        step();
        input_valid_i = 1'b0;
        exp_instret = exp_instret + 64'd1;
        chk("release_write", {63'd0, write_a}, 64'd1);
        chk("release_waddr", {59'd0, waddr_a}, 64'd9);
        chk("release_wdata", {32'd0, wdata_a}, 64'h0000A5A5);
        chk("release_instret", instret_a, exp_instret);
        step();
        chk("release_single", {63'd0, write_a}, 64'd0);
        chk("release_instret_hold", instret_a, exp_instret);

        // Reset right after a transfer drops the pending write and restores the counter.
        drive(1'b1, 5'd10, 32'h00000077, 1'b0, 2'd0, 1'b0, 2'd0, 32'h0);
        input_valid_i = 1'b1;
        step();
        input_valid_i = 1'b0;
        chk("pre_rst_write", {63'd0, write_a}, 64'd1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_ready", {63'd0, ready_a}, 64'd0);
        step();
        chk("mid_rst_write", {63'd0, write_a}, 64'd0);
        chk("mid_rst_waddr", {59'd0, waddr_a}, 64'd0);
        chk("mid_rst_instret", instret_a, 64'd0);
        chk("mid_rst_instret_wrapinst", instret_b, 64'hFFFF_FFFF_FFFF_FFFF);
        rst_i = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
